// File: rtl/uart_pkg.sv
// Shared UART definitions: default baud divisor, frame geometry, counter widths
// and the transmitter state encoding. Imported by the baud generator and the TX top.
package uart_pkg;

  localparam int BAUD_DIV_DEF = 868;  // default terminal count; bit period = BAUD_DIV+1 clks
  localparam int FRAME_BITS   = 10;   // start + 8 data + stop
  localparam int BAUD_W       = 10;   // baud counter width, BAUD_DIV must stay below 1024
  localparam int BIT_W        = 4;    // bit counter width, counts 0..FRAME_BITS-1

  typedef enum logic {
    IDLE = 1'b0,
    TXS  = 1'b1
  } tx_state_t;

endpackage

// File: rtl/uart_tx_if.sv
// Host-side handshake bundle of the UART transmitter.
//   tx_data   byte to queue, sampled only when trmt is accepted
//   trmt      1-cycle queue request
//   hold_full holding register occupied; requests are dropped while high
//   busy      a frame is shifting out
//   tx_done   1-cycle pulse after the stop bit of a frame has completed
// master = host side, slave = transmitter side.
interface uart_tx_if;
  logic [7:0] tx_data;
  logic       trmt;
  logic       hold_full;
  logic       busy;
  logic       tx_done;

  modport master (output tx_data, output trmt,
                  input  hold_full, input busy, input tx_done);
  modport slave  (input  tx_data, input trmt,
                  output hold_full, output busy, output tx_done);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer shared by the UART transmitter and receiver.
// Counts 0..BAUD_DIV while enabled and flags the last clock of each bit period.
//   clk, rst_n  clock, asynchronous active-low reset
//   en          count enable (frame in progress)
//   clr         synchronous clear, wins over counting
//   shift       high during the clock in which the counter sits at BAUD_DIV
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic shift
);

  localparam logic [BAUD_W-1:0] TERM = BAUD_W'(BAUD_DIV);

  logic [BAUD_W-1:0] baud_cntr;

  assign shift = en && (baud_cntr == TERM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cntr <= '0;
    end else if (clr || shift) begin
      baud_cntr <= '0;
    end else if (en) begin
      baud_cntr <= baud_cntr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-entry holding register so the host can queue
// the next byte while the current frame shifts out; queued frames follow the
// previous stop bit with no idle gap.
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         uart_tx_if.slave: tx_data/trmt in, hold_full/busy/tx_done out
//   TX          registered serial line, idles high
module uart_tx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic      clk,
  input  logic      rst_n,
  uart_tx_if.slave  bus,
  output logic      TX
);

  tx_state_t        state;
  logic [9:0]       shift_reg;
  logic [7:0]       hold_reg;
  logic             hold_full;
  logic             busy;
  logic             tx_done;
  logic [BIT_W-1:0] bit_cntr;
  logic             tx_q;

  logic shift;
  logic frame_end;
  logic load;

  // Last shift of a frame: the stop bit has now been held for a full period.
  assign frame_end = shift && (bit_cntr == BIT_W'(FRAME_BITS - 1));
  // Move the holding register into the shifter, either from idle or straight
  // after a stop bit so the next start bit follows without a gap.
  assign load      = hold_full && ((state == IDLE) || frame_end);

  uart_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == TXS),
    .clr   (load),
    .shift (shift)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_reg <= 10'h3FF;
      hold_reg  <= '0;
      hold_full <= 1'b0;
      busy      <= 1'b0;
      tx_done   <= 1'b0;
      bit_cntr  <= '0;
      tx_q      <= 1'b1;
    end else begin
      tx_done <= 1'b0;

      // Accept only into an empty holding register; load below needs it full,
      // so the two never touch hold_full in the same cycle.
      if (bus.trmt && !hold_full) begin
        hold_reg  <= bus.tx_data;
        hold_full <= 1'b1;
      end

      if (frame_end) begin
        tx_done <= 1'b1;
      end

      if (load) begin
        shift_reg <= {1'b1, hold_reg, 1'b0};
        hold_full <= 1'b0;
        bit_cntr  <= '0;
        tx_q      <= 1'b0;  // start bit goes out on the same edge as the load
        busy      <= 1'b1;
        state     <= TXS;
      end else begin
        case (state)
          IDLE: begin
            tx_q <= 1'b1;
          end
          TXS: begin
            if (frame_end) begin
              bit_cntr <= '0;
              tx_q     <= 1'b1;
              busy     <= 1'b0;
              state    <= IDLE;
            end else if (shift) begin
              shift_reg <= {1'b1, shift_reg[9:1]};
              tx_q      <= shift_reg[1];  // bit that becomes shift_reg[0]
              bit_cntr  <= bit_cntr + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.hold_full = hold_full;
  assign bus.busy      = busy;
  assign bus.tx_done   = tx_done;
  assign TX            = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

  localparam int B        = 4;
  localparam int BIT_CLKS = B + 1;

  logic clk;
  logic rst_n;
  logic TX;

  int checks;
  int failures;

  uart_tx_if bus ();

  uart_tx #(.BAUD_DIV(B)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .TX    (TX)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue one byte; returns 1 ns after the accepting edge. tx_data is then
  // scrambled to show the frame does not depend on it afterwards.
  task automatic send(input logic [7:0] b);
    bus.tx_data = b;
    bus.trmt    = 1'b1;
    tick();
    bus.trmt    = 1'b0;
    bus.tx_data = ~b;
  endtask

  // Called while the start bit of a frame is on TX (1 ns after its edge).
  // Every bit must hold for BIT_CLKS samples; returns at the tx_done edge.
  task automatic expect_frame(input string name, input logic [7:0] b);
    logic [9:0] f;
    logic       bad;
    logic       seen;
    logic       early;
    f = {1'b1, b, 1'b0};
    early = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bad  = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < BIT_CLKS; c++) begin
        if (TX !== f[i]) begin
          bad  = 1'b1;
          seen = TX;
        end
        if (!(i == 0 && c == 0) && tx_done_now() !== 1'b0) early = 1'b1;
        tick();
      end
      checks++;
      if (bad) begin
        failures++;
        $display("FAIL %s bit%0d: TX=%b required %b", name, i, seen, f[i]);
      end
    end
    checks++;
    if (early) begin
      failures++;
      $display("FAIL %s early_done: tx_done seen inside frame, required none", name);
    end
    checks++;
    if (bus.tx_done !== 1'b1) begin
      failures++;
      $display("FAIL %s done: tx_done=%b required 1", name, bus.tx_done);
    end
  endtask

  function automatic logic tx_done_now();
    return bus.tx_done;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus.trmt = 1'b0;
    bus.tx_data = 8'h00;
    repeat (3) tick();
    checks++; if (TX !== 1'b1) begin failures++; $display("FAIL rst_tx: TX=%b required 1", TX); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy: busy=%b required 0", bus.busy); end
    checks++; if (bus.hold_full !== 1'b0) begin failures++; $display("FAIL rst_hold: hold_full=%b required 0", bus.hold_full); end
    checks++; if (bus.tx_done !== 1'b0) begin failures++; $display("FAIL rst_done: tx_done=%b required 0", bus.tx_done); end
    rst_n = 1'b1;
    repeat (5) tick();
    checks++; if (TX !== 1'b1) begin failures++; $display("FAIL idle_tx: TX=%b required 1", TX); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL idle_busy: busy=%b required 0", bus.busy); end
    checks++; if (bus.tx_done !== 1'b0) begin failures++; $display("FAIL idle_done: tx_done=%b required 0", bus.tx_done); end
  endtask

  task automatic test_single();
    send(8'hA5);
    checks++; if (bus.hold_full !== 1'b1) begin failures++; $display("FAIL t2_accept: hold_full=%b required 1", bus.hold_full); end
    checks++; if (TX !== 1'b1) begin failures++; $display("FAIL t2_pre_start: TX=%b required 1", TX); end
    tick();
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL t2_busy: busy=%b required 1", bus.busy); end
    checks++; if (bus.hold_full !== 1'b0) begin failures++; $display("FAIL t2_unload: hold_full=%b required 0", bus.hold_full); end
    expect_frame("t2", 8'hA5);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL t2_busy_end: busy=%b required 0", bus.busy); end
    checks++; if (TX !== 1'b1) begin failures++; $display("FAIL t2_tx_end: TX=%b required 1", TX); end
    tick();
    checks++; if (bus.tx_done !== 1'b0) begin failures++; $display("FAIL t2_done_pulse: tx_done=%b required 0", bus.tx_done); end
  endtask

  task automatic test_back_to_back();
    send(8'h55);
    tick();
    fork
      expect_frame("t3_f1", 8'h55);
      begin
        repeat (7) tick();
        send(8'h0F);
        checks++; if (bus.hold_full !== 1'b1) begin failures++; $display("FAIL t3_queue: hold_full=%b required 1", bus.hold_full); end
      end
    join
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL t3_busy_gap: busy=%b required 1", bus.busy); end
    checks++; if (bus.hold_full !== 1'b0) begin failures++; $display("FAIL t3_reload: hold_full=%b required 0", bus.hold_full); end
    expect_frame("t3_f2", 8'h0F);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL t3_busy_end: busy=%b required 0", bus.busy); end
    tick();
  endtask

  task automatic test_overflow();
    logic bad;
    send(8'h11);
    tick();
    fork
      expect_frame("t4_f1", 8'h11);
      begin
        repeat (5) tick();
        send(8'h22);
        repeat (5) tick();
        send(8'h33);
        checks++; if (bus.hold_full !== 1'b1) begin failures++; $display("FAIL t4_hold: hold_full=%b required 1", bus.hold_full); end
        repeat (5) tick();
        send(8'h44);
      end
    join
    expect_frame("t4_f2", 8'h22);
    bad = 1'b0;
    repeat (60) begin
      tick();
      if (TX !== 1'b1 || bus.busy !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) begin failures++; $display("FAIL t4_no_third: TX/busy active after frame 2, required idle"); end
    checks++; if (bus.hold_full !== 1'b0) begin failures++; $display("FAIL t4_hold_end: hold_full=%b required 0", bus.hold_full); end
  endtask

  task automatic test_reset_mid_frame();
    send(8'hC3);
    tick();
    repeat (4 * BIT_CLKS + 2) tick();
    send(8'h99);
    checks++; if (TX !== 1'b0) begin failures++; $display("FAIL t5_bit3: TX=%b required 0", TX); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (TX !== 1'b1) begin failures++; $display("FAIL t5_async_tx: TX=%b required 1", TX); end
    checks++; if (bus.hold_full !== 1'b0) begin failures++; $display("FAIL t5_hold: hold_full=%b required 0", bus.hold_full); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL t5_busy: busy=%b required 0", bus.busy); end
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    checks++; if (TX !== 1'b1 || bus.busy !== 1'b0) begin failures++; $display("FAIL t5_idle: TX=%b busy=%b required 1/0", TX, bus.busy); end
    send(8'h3C);
    tick();
    expect_frame("t5", 8'h3C);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL t5_busy_end: busy=%b required 0", bus.busy); end
    tick();
  endtask

  task automatic test_random_stream();
    logic [7:0] bytes [6];
    for (int k = 0; k < 6; k++) bytes[k] = 8'($urandom_range(0, 255));
    send(bytes[0]);
    tick();
    for (int k = 0; k < 6; k++) begin
      fork
        expect_frame("t6", bytes[k]);
        begin
          if (k < 5) begin
            repeat (3) tick();
            send(bytes[k + 1]);
          end
        end
      join
    end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL t6_busy_end: busy=%b required 0", bus.busy); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
    test_random_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
